// File: rtl/aqed_fifo_multi_dup.sv
`default_nettype none
// ============================================================================
// Module  : aqed_fifo_multi_dup
// Purpose : A-QED self-consistency monitor for FIFO-class memory cores.
//           It sits between the verification harness and the DUT write/read
//           ports. It tags one original write and up to NUM_DUP duplicate
//           writes that carry the same data. It captures the read data that
//           comes back at those ordinal positions. It then reports whether
//           every duplicate read matched the original read.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           clk_en            - global enable; state is frozen while low
//           flush             - DUT flush; aborts an in-progress check
//           exec_dup          - harness asks for original/duplicate issue
//           wen_in, full      - harness write request, DUT full
//           data_in/data_out  - harness write data in, data driven to DUT
//           ren_in, empty     - read request to DUT, DUT empty
//           valid_out         - DUT read data valid
//           data_out_in       - DUT read data
//           qed_done          - all duplicates captured
//           qed_check         - no mismatch observed so far
//           qed_proto_err     - sticky: expected read data never arrived
// Revision: 1.0 - initial release
// ============================================================================
module aqed_fifo_multi_dup #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_DUP      = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  exec_dup,
  input  logic                  wen_in,
  input  logic                  full,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ren_in,
  input  logic                  empty,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] data_out_in,
  output logic                  qed_done,
  output logic                  qed_check,
  output logic                  qed_proto_err
);

  // Index width must also hold the terminal value NUM_DUP.
  localparam int c_IDX_W = $clog2(NUM_DUP + 1);
  localparam logic [c_IDX_W-1:0] c_NUM_DUP  = c_IDX_W'(NUM_DUP);
  localparam logic [c_IDX_W-1:0] c_LAST_DUP = c_IDX_W'(NUM_DUP - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ORIG     = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_WIDTH-1:0]    r_in_count;
  logic [CNT_WIDTH-1:0]    r_out_count;
  logic [CNT_WIDTH-1:0]    r_orig_tag;
  logic [CNT_WIDTH-1:0]    r_dup_tag [NUM_DUP];
  logic [DATA_WIDTH-1:0]   r_orig_in;
  logic [DATA_WIDTH-1:0]   r_orig_out;
  logic                    r_orig_captured;
  logic [c_IDX_W-1:0]      r_issue_idx;   // duplicates issued so far
  logic [c_IDX_W-1:0]      r_dup_idx;     // next duplicate expected on read
  logic                    r_mismatch;
  logic                    r_proto_err;
  logic [READ_LATENCY-1:0] r_rd_pipe;

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_flush;
  logic                    w_active;
  logic                    w_abort;
  logic                    w_rd_exp;
  logic                    w_capture;
  logic                    w_orig_issue;
  logic                    w_dup_issue;
  logic                    w_last_issue;
  logic [CNT_WIDTH-1:0]    w_cur_tag;
  logic                    w_orig_hit;
  logic                    w_dup_hit;
  logic                    w_last_hit;
  logic [READ_LATENCY-1:0] w_pipe_next;

  assign w_wr_acc  = clk_en & wen_in & ~full  & ~flush;
  assign w_rd_acc  = clk_en & ren_in & ~empty & ~flush;
  assign w_flush   = clk_en & flush;
  assign w_active  = (r_state == S_ORIG) | (r_state == S_WAIT_OUT);
  assign w_abort   = w_flush & w_active;
  assign w_rd_exp  = r_rd_pipe[READ_LATENCY-1];
  // A flush discards the read pipe, so a capture in a flush cycle is dropped.
  assign w_capture = clk_en & w_rd_exp & valid_out & ~flush;

  assign w_orig_issue = (r_state == S_IDLE) & w_wr_acc & exec_dup;
  assign w_dup_issue  = (r_state == S_ORIG) & w_wr_acc & exec_dup;
  assign w_last_issue = w_dup_issue & (r_issue_idx == c_LAST_DUP);

  // Select the tag of the next expected duplicate. A loop mux keeps the
  // index in range even when r_dup_idx has reached NUM_DUP.
  always_comb begin
    w_cur_tag = '1;
    for (int k = 0; k < NUM_DUP; k++) begin
      if (r_dup_idx == c_IDX_W'(k)) begin
        w_cur_tag = r_dup_tag[k];
      end
    end
  end

  assign w_orig_hit = w_capture & ~r_orig_captured & (r_out_count == r_orig_tag);
  assign w_dup_hit  = w_capture & (r_dup_idx != c_NUM_DUP) & (r_out_count == w_cur_tag);
  assign w_last_hit = w_dup_hit & (r_dup_idx == c_LAST_DUP);

  always_comb begin
    w_pipe_next    = '0;
    w_pipe_next[0] = w_rd_acc;
    for (int i = 1; i < READ_LATENCY; i++) begin
      w_pipe_next[i] = r_rd_pipe[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and the write-data steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    data_out     = data_in;
    if (w_dup_issue) begin
      data_out = r_orig_in;
    end
    case (r_state)
      S_IDLE: begin
        if (w_orig_issue) w_state_next = S_ORIG;
      end
      S_ORIG: begin
        if (w_abort)           w_state_next = S_IDLE;
        else if (w_last_hit)   w_state_next = S_DONE;
        else if (w_last_issue) w_state_next = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (w_abort)         w_state_next = S_IDLE;
        else if (w_last_hit) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, tags, captured data and sticky flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_count      <= '0;
      r_out_count     <= '0;
      r_orig_tag      <= '1;
      for (int k = 0; k < NUM_DUP; k++) r_dup_tag[k] <= '1;
      r_orig_in       <= '0;
      r_orig_out      <= '0;
      r_orig_captured <= 1'b0;
      r_issue_idx     <= '0;
      r_dup_idx       <= '0;
      r_mismatch      <= 1'b0;
      r_proto_err     <= 1'b0;
      r_rd_pipe       <= '0;
    end else begin
      // A read was accepted READ_LATENCY cycles ago but no data came back.
      if (clk_en & w_rd_exp & ~valid_out) begin
        r_proto_err <= 1'b1;
      end
      if (w_flush) begin
        r_in_count  <= '0;
        r_out_count <= '0;
        r_rd_pipe   <= '0;
        // Only an in-progress check is aborted; a finished one keeps its
        // tags so it cannot re-trigger on the restarted counters.
        if (w_active) begin
          r_orig_tag      <= '1;
          for (int k = 0; k < NUM_DUP; k++) r_dup_tag[k] <= '1;
          r_orig_captured <= 1'b0;
          r_issue_idx     <= '0;
          r_dup_idx       <= '0;
        end
      end else if (clk_en) begin
        r_rd_pipe <= w_pipe_next;
        if (w_wr_acc) begin
          r_in_count <= r_in_count + CNT_WIDTH'(1);
        end
        if (w_capture) begin
          r_out_count <= r_out_count + CNT_WIDTH'(1);
        end
        if (w_orig_issue) begin
          r_orig_in  <= data_in;
          r_orig_tag <= r_in_count;
        end
        if (w_dup_issue) begin
          r_issue_idx <= r_issue_idx + c_IDX_W'(1);
          for (int k = 0; k < NUM_DUP; k++) begin
            if (r_issue_idx == c_IDX_W'(k)) begin
              r_dup_tag[k] <= r_in_count;
            end
          end
        end
        if (w_orig_hit) begin
          r_orig_out      <= data_out_in;
          r_orig_captured <= 1'b1;
        end
        if (w_dup_hit) begin
          if (data_out_in != r_orig_out) begin
            r_mismatch <= 1'b1;
          end
          r_dup_idx <= r_dup_idx + c_IDX_W'(1);
        end
      end
    end
  end

  assign qed_done      = (r_state == S_DONE);
  assign qed_check     = ~r_mismatch;
  assign qed_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_aqed_fifo_multi_dup.sv
`default_nettype none
// ============================================================================
// Module  : tb_aqed_fifo_multi_dup
// Purpose : Bench for aqed_fifo_multi_dup (NUM_DUP=3, READ_LATENCY=2).
//           It emulates a FIFO DUT behind the monitor and keeps a
//           transaction-level model of the check. A compare process tests
//           every output on every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aqed_fifo_multi_dup;

  localparam int DW    = 16;
  localparam int ND    = 3;
  localparam int CW    = 32;
  localparam int RL    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b0;
  logic          flush = 1'b0;
  logic          exec_dup = 1'b0;
  logic          wen_in = 1'b0;
  logic          ren_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          full, empty, valid_out;
  logic [DW-1:0] data_out, data_out_in;
  logic          qed_done, qed_check, qed_proto_err;

  always #5 clk = ~clk;

  aqed_fifo_multi_dup #(
    .DATA_WIDTH(DW), .NUM_DUP(ND), .CNT_WIDTH(CW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .exec_dup(exec_dup), .wen_in(wen_in), .full(full), .data_in(data_in),
    .data_out(data_out), .ren_in(ren_in), .empty(empty),
    .valid_out(valid_out), .data_out_in(data_out_in),
    .qed_done(qed_done), .qed_check(qed_check), .qed_proto_err(qed_proto_err)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // -------------------- emulated FIFO DUT --------------------
  logic [DW-1:0] fifo[$];
  int            fifo_cnt = 0;
  bit            force_full = 0;
  bit [RL-1:0]   dv = '0;
  bit [RL-1:0]   dx = '0;
  logic [DW-1:0] dd [RL];
  int            pop_n = 0;
  int            corrupt_ord = -1;
  int            drop_ord = -1;
  logic [DW-1:0] push_d = '0;
  bit            noise_v = 0;
  logic [DW-1:0] noise_d = '0;

  assign full        = (fifo_cnt >= DEPTH) || force_full;
  assign empty       = (fifo_cnt == 0);
  assign valid_out   = dv[RL-1] ? !dx[RL-1] : noise_v;
  assign data_out_in = dv[RL-1] ? dd[RL-1] : noise_d;

  task automatic env_step();
    bit wa, ra;
    if (reset || (clk_en && flush)) begin
      fifo.delete(); dv = '0; dx = '0; pop_n = 0;
    end else if (clk_en) begin
      wa = wen_in && !full;
      ra = ren_in && !empty;
      for (int i = RL-1; i > 0; i--) begin
        dv[i] = dv[i-1]; dd[i] = dd[i-1]; dx[i] = dx[i-1];
      end
      dv[0] = ra;
      dx[0] = 0;
      if (ra) begin
        dd[0] = fifo.pop_front();
        if (pop_n == corrupt_ord) dd[0] = dd[0] ^ 16'h0001;
        dx[0] = (pop_n == drop_ord);
        pop_n++;
      end
      if (wa) fifo.push_back(push_d);
    end
    fifo_cnt = fifo.size();
    noise_v  = ($urandom_range(0, 7) == 0);
    noise_d  = DW'($urandom);
  endtask

  // -------------------- behavioural model --------------------
  // phase: 0 idle, 1 issuing duplicates, 2 waiting for reads, 3 done
  int            m_phase;
  logic [31:0]   m_in, m_out, m_otag;
  logic [DW-1:0] m_orig, m_ord;
  bit            m_oseen, m_mis, m_proto;
  logic [31:0]   m_dtags[$];
  int            m_issued, m_capt, m_ecnt;
  int            m_rq[$];   // enabled-cycle index at which each read was accepted

  task automatic model_step();
    bit rexp, cap;
    if (reset) begin
      m_phase = 0; m_in = 0; m_out = 0; m_otag = '1; m_orig = '0; m_ord = '0;
      m_oseen = 0; m_mis = 0; m_proto = 0; m_dtags.delete(); m_issued = 0;
      m_capt = 0; m_rq.delete(); m_ecnt = 0;
    end else if (clk_en) begin
      rexp = (m_rq.size() > 0) && (m_rq[0] == m_ecnt - RL);
      if (rexp) m_rq.delete(0);
      cap = rexp && valid_out;
      if (rexp && !valid_out) m_proto = 1;
      if (flush) begin
        if (m_phase == 1 || m_phase == 2) begin
          m_phase = 0; m_oseen = 0; m_otag = '1; m_dtags.delete();
          m_issued = 0; m_capt = 0;
        end
        m_in = 0; m_out = 0; m_rq.delete();
      end else begin
        if (cap) begin
          if (m_out == m_otag && !m_oseen) begin
            m_ord = data_out_in; m_oseen = 1;
          end else if (m_dtags.size() > 0 && m_out == m_dtags[0]) begin
            if (data_out_in != m_ord) m_mis = 1;
            m_dtags.delete(0);
            m_capt++;
            if (m_capt == ND) m_phase = 3;
          end
          m_out++;
        end
        if (wen_in && !full) begin
          if (m_phase == 0 && exec_dup) begin
            m_orig = data_in; m_otag = m_in; m_phase = 1;
          end else if (m_phase == 1 && exec_dup) begin
            m_dtags.push_back(m_in);
            m_issued++;
            if (m_issued == ND) m_phase = 2;
          end
          m_in++;
        end
        if (ren_in && !empty) m_rq.push_back(m_ecnt);
      end
      m_ecnt++;
    end
  endtask

  // -------------------- per-cycle compare --------------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (chk_en) begin
      e = (m_phase == 1 && clk_en && wen_in && !full && !flush && exec_dup) ? m_orig : data_in;
      check("data_out", data_out, e);
      check("qed_done", qed_done, (m_phase == 3));
      check("qed_check", qed_check, !m_mis);
      check("qed_proto_err", qed_proto_err, m_proto);
    end
  end

  // -------------------- stimulus helpers --------------------
  task automatic tick();
    @(negedge clk);
    push_d = data_out;
    @(posedge clk);
    model_step();
    #1;
    env_step();
  endtask

  task automatic set_in(input bit w, input bit ex, input bit r, input bit fl, input logic [DW-1:0] d);
    clk_en = 1; wen_in = w; exec_dup = ex; ren_in = r; flush = fl; data_in = d;
  endtask

  task automatic do_reset();
    reset = 1; force_full = 0;
    set_in(0, 0, 0, 0, '0);
    tick();
    chk_en = 1;
    tick();
    reset = 0;
  endtask

  task automatic wait_done();
    set_in(0, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) begin
      if (qed_done) break;
      tick();
    end
  endtask

  // Original, one other write, three duplicates with data_in=0, then 5 reads.
  task automatic basic_seq(input logic [DW-1:0] od);
    set_in(1, 1, 0, 0, od);      tick();
    set_in(1, 0, 0, 0, 16'h1111); tick();
    for (int k = 0; k < ND; k++) begin
      set_in(1, 1, 0, 0, 16'h0000);
      #2 check("dup_drive_lit", data_out, od);
      tick();
    end
    for (int k = 0; k < ND + 2; k++) begin
      set_in(0, 0, 1, 0, '0);
      tick();
    end
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < RL; i++) dd[i] = '0;
    do_reset();
    check("reset_done_lit",  qed_done, 0);
    check("reset_check_lit", qed_check, 1);
    check("reset_proto_lit", qed_proto_err, 0);

    // Matching duplicates.
    basic_seq(16'hA5A5);
    check("t1_done_lit",  qed_done, 1);
    check("t1_check_lit", qed_check, 1);

    // First duplicate (read ordinal 2) returns 0xA5A4.
    do_reset();
    corrupt_ord = 2;
    basic_seq(16'hA5A5);
    check("t2_done_lit",  qed_done, 1);
    check("t2_check_lit", qed_check, 0);
    for (int i = 0; i < 5; i++) tick();
    check("t2_hold_lit", qed_check, 0);
    corrupt_ord = -1;

    // Flush after original and one duplicate, then a fresh check.
    do_reset();
    set_in(1, 1, 0, 0, 16'h5555); tick();
    set_in(1, 1, 0, 0, 16'h0000); tick();
    set_in(0, 0, 0, 1, 16'h0000); tick();
    check("t3_flush_done_lit", qed_done, 0);
    set_in(1, 1, 0, 0, 16'h1234); tick();
    for (int k = 0; k < ND; k++) begin
      set_in(1, 1, 0, 0, 16'hFFFF);
      #2 check("t3_dup_drive_lit", data_out, 16'h1234);
      tick();
    end
    for (int k = 0; k < ND + 1; k++) begin set_in(0, 0, 1, 0, '0); tick(); end
    wait_done();
    check("t3_done_lit",  qed_done, 1);
    check("t3_check_lit", qed_check, 1);

    // Read accepted but valid never arrives.
    do_reset();
    drop_ord = 0;
    set_in(1, 0, 0, 0, 16'h7777); tick();
    set_in(0, 0, 1, 0, '0);       tick();
    set_in(0, 0, 0, 0, '0);
    for (int i = 0; i < RL + 1; i++) tick();
    check("t4_proto_lit", qed_proto_err, 1);
    set_in(0, 0, 0, 1, '0); tick();
    set_in(0, 0, 0, 0, '0); tick();
    check("t4_proto_flush_lit", qed_proto_err, 1);
    drop_ord = -1;
    do_reset();
    check("t4_proto_reset_lit", qed_proto_err, 0);

    // full blocks a duplicate issue; it completes once full drops.
    do_reset();
    set_in(1, 1, 0, 0, 16'hBEEF); tick();
    force_full = 1;
    set_in(1, 1, 0, 0, 16'hCAFE);
    #2 check("t5_full_drive_lit", data_out, 16'hCAFE);
    tick();
    force_full = 0;
    for (int k = 0; k < ND; k++) begin
      set_in(1, 1, 0, 0, 16'h0000);
      #2 check("t5_dup_drive_lit", data_out, 16'hBEEF);
      tick();
    end
    for (int k = 0; k < ND + 1; k++) begin set_in(0, 0, 1, 0, '0); tick(); end
    wait_done();
    check("t5_done_lit",  qed_done, 1);
    check("t5_check_lit", qed_check, 1);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      corrupt_ord = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 12));
      drop_ord    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      for (int c = 0; c < 400; c++) begin
        clk_en     = ($urandom_range(0, 9) != 0);
        wen_in     = $urandom_range(0, 1);
        exec_dup   = ($urandom_range(0, 2) == 0);
        ren_in     = ($urandom_range(0, 2) != 0);
        flush      = ($urandom_range(0, 79) == 0);
        force_full = ($urandom_range(0, 7) == 0);
        data_in    = DW'($urandom);
        reset      = ($urandom_range(0, 299) == 0);
        tick();
      end
      reset = 0;
    end
    corrupt_ord = -1;
    drop_ord    = -1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aqed_fifo_multi_dup.md
# aqed_fifo_multi_dup

A-QED self-consistency monitor for FIFO-class memory-core configurations. It sits between the verification harness and the DUT write/read ports. It injects one original write followed by up to NUM_DUP duplicate writes of the same data, tracks their ordinal positions, and captures the matching read data. It then reports whether every duplicate read matches the original. Relative to the single-duplicate monitor, it adds parametrised width, multiple duplicates, configurable read latency, flush abort and protocol-error detection.

## Interface
- DATA_WIDTH, 16, data bus width
- NUM_DUP, 1, number of duplicate writes per check (1..8)
- CNT_WIDTH, 32, width of transaction counters and tags
- READ_LATENCY, 1, cycles from accepted read (ren_in & ~empty) to valid_out (1..4)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  global enable; no state changes when low
- flush  in  1  DUT flush; aborts an in-progress check
- exec_dup  in  1  harness request to issue original/duplicate on this write
- wen_in  in  1  harness write request
- full  in  1  DUT full
- data_in  in  DATA_WIDTH  harness write data
- data_out  out  DATA_WIDTH  write data driven to DUT
- ren_in  in  1  read request to DUT
- empty  in  1  DUT empty
- valid_out  in  1  DUT read-data valid
- data_out_in  in  DATA_WIDTH  DUT read data
- qed_done  out  1  all duplicates captured
- qed_check  out  1  no mismatch observed so far
- qed_proto_err  out  1  sticky: expected read data did not arrive

## Operation
- wr_acc = clk_en & wen_in & ~full & ~flush. rd_acc = clk_en & ren_in & ~empty & ~flush.
- FSM states: IDLE, ORIG, WAIT_OUT, DONE. Reset state: IDLE.
- IDLE: if wr_acc & exec_dup, this write is the original. Latch orig_in <= data_in and orig_tag <= in_count, then go to ORIG.
- ORIG: each wr_acc & exec_dup is duplicate k (k = 0..NUM_DUP-1). Latch dup_tag[k] <= in_count and drive data_out = orig_in combinationally in that cycle. After duplicate NUM_DUP-1, go to WAIT_OUT.
- All other cycles: data_out = data_in.
- in_count increments on every wr_acc (original, duplicate or other). It wraps modulo 2^CNT_WIDTH.
- Read pipe: shift register of READ_LATENCY bits, fed with rd_acc. rd_exp = last stage.
- A capture occurs when clk_en & rd_exp & valid_out. On each capture out_count increments and wraps.
  - out_count == orig_tag, orig not yet captured: orig_out <= data_out_in.
  - out_count == dup_tag[j] (j = next expected duplicate index): compare data_out_in with orig_out. On inequality set mismatch (sticky), then j++.
- When j reaches NUM_DUP (possible in ORIG or WAIT_OUT), go to DONE. DONE holds until reset.
- clk_en & rd_exp & ~valid_out sets qed_proto_err (sticky until reset).
- flush in ORIG or WAIT_OUT:
  - return to IDLE;
  - clear in_count, out_count, j, read pipe and orig-captured flag;
  - set tags to all-ones;
  - mismatch and qed_proto_err are kept.
- flush in IDLE or DONE only clears counters and the read pipe.
- Tag reset value is all-ones, so no capture matches before issue.

## Timing
- Reset values (on the cycle after reset is sampled high):
  - qed_done=0, qed_check=1, qed_proto_err=0;
  - counters=0, tags=all-ones, orig_in=0, orig_out=0;
  - read pipe cleared.
- data_out is combinational from state and inputs: zero latency.
- Tag and counter updates are visible the cycle after the accepted write or capture.
- qed_done = (state==DONE): asserts the cycle after the last duplicate capture.
- qed_check = ~mismatch: deasserts the cycle after the mismatching capture.
- Simultaneous wr_acc and capture in one cycle: both are processed.
- Simultaneous reset and any other input: reset wins. Reset mid-check returns to IDLE and clears mismatch.
- clk_en low: read pipe does not shift and no counters move. data_out still follows the combinational rule.

## Test plan
- NUM_DUP=1, READ_LATENCY=1: write 0xA5A5 with exec_dup, one other write 0x1111, then exec_dup write with data_in=0x0000.
  - Required: data_out=0xA5A5 on the duplicate cycle.
  - Read all three: qed_done=1 and qed_check=1 one cycle after the third read data.
- Same sequence, but the DUT returns 0xA5A4 for the duplicate: qed_check=0 and qed_done=1 on the same cycle; both hold until reset.
- NUM_DUP=3, READ_LATENCY=2: orig 0x00FF, interleave other writes, three duplicates with exec_dup.
  - Required: every duplicate drives 0x00FF.
  - Required: qed_done only after the third duplicate is read.
- flush asserted after orig and one duplicate: FSM returns to IDLE, a fresh orig 0x1234 check completes with qed_check=1, and tags restart from in_count=0.
- ren_in & ~empty with valid_out held low READ_LATENCY cycles later: qed_proto_err=1 the next cycle; it stays 1 across flush and clears only on reset.
- full=1 during an exec_dup write: no issue, in_count unchanged; the issue completes once full drops.
